// File: rtl/sim_msg_pkg.sv
// Shared constants, state encoding and header helper for the message framer.
package sim_msg_pkg;

  localparam logic [15:0] MAGIC = 16'hA5C3;
  localparam int SEQ_W = 8;
  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    TRL  = 2'd3
  } state_t;

  function automatic logic [31:0] header_word(input logic [SEQ_W-1:0] seq,
                                              input logic [LEN_W-1:0] len);
    return {MAGIC, seq, len};
  endfunction

endpackage

// File: rtl/sim_msg_buf.sv
// Single-clock payload buffer: writes in arrival order, reads back in the same order.
module sim_msg_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge i_clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    end
  end

  // Storage is never reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/sim_msg_framer.sv
// Collects one message into a buffer, then emits header, payload and an XOR
// trailer toward the socket bridge.
module sim_msg_framer
  import sim_msg_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 16
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [31:0]       frame_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  wcnt, len, pay_cnt;
  logic [LEN_W-1:0]  wcnt_inc, pay_cnt_inc;
  logic [SEQ_W-1:0]  seq;
  logic [DATA_W-1:0] csum, buf_rd_data, hdr_word;
  logic              s_fire, m_fire, close_frame, pay_fire, trl_fire;

  assign wcnt_inc    = wcnt + LEN_W'(1);
  assign pay_cnt_inc = pay_cnt + LEN_W'(1);
  assign s_fire      = s_valid && (state == FILL);
  assign m_fire      = m_ready && (state != FILL);
  assign close_frame = s_fire && (s_last || (wcnt_inc == MAX_LEN));
  assign pay_fire    = m_fire && (state == PAY);
  assign trl_fire    = m_fire && (state == TRL);
  assign hdr_word    = DATA_W'(header_word(seq, len));

  sim_msg_buf #(
    .DATA_W(DATA_W),
    .DEPTH (MAX_WORDS)
  ) u_buf (
    .i_clk  (i_clk),
    .clear  (reset || trl_fire),
    .wr_en  (s_fire),
    .wr_data(s_data),
    .rd_en  (pay_fire),
    .rd_data(buf_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    m_data    = '0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        if (close_frame) state_nxt = HDR;
      end
      HDR: begin
        m_valid = 1'b1;
        m_data  = hdr_word;
        if (m_ready) state_nxt = PAY;
      end
      PAY: begin
        m_valid = 1'b1;
        m_data  = buf_rd_data;
        if (m_ready && (pay_cnt_inc == len)) state_nxt = TRL;
      end
      TRL: begin
        m_valid = 1'b1;
        m_last  = 1'b1;
        m_data  = hdr_word ^ csum;
        if (m_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Payload XOR is folded in as words arrive, so the trailer needs only the header term.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      wcnt      <= '0;
      len       <= '0;
      pay_cnt   <= '0;
      seq       <= '0;
      frame_cnt <= '0;
      csum      <= '0;
    end else begin
      if (s_fire) begin
        wcnt <= wcnt_inc;
        csum <= csum ^ s_data;
        if (close_frame) len <= wcnt_inc;
      end
      if (pay_fire) pay_cnt <= pay_cnt_inc;
      if (trl_fire) begin
        seq       <= seq + SEQ_W'(1);
        frame_cnt <= frame_cnt + 32'd1;
        wcnt      <= '0;
        pay_cnt   <= '0;
        csum      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sim_msg_framer.sv
// Directed self-checking bench for sim_msg_framer with a beat monitor and stall checks.
module tb_sim_msg_framer;

  logic        i_clk;
  logic        reset;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [31:0] frame_cnt;

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  logic        toggle_en = 1'b0;
  logic [32:0] got_q[$];
  logic [31:0] exp_words[$];
  logic        prev_stall = 1'b0;
  logic        prev_last;
  logic [31:0] prev_data;

  sim_msg_framer #(
    .DATA_W   (32),
    .MAX_WORDS(16)
  ) dut (
    .i_clk    (i_clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .frame_cnt(frame_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Output ready is either held high or toggled every cycle for stall testing.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      if (toggle_en) m_ready = ~m_ready;
      else           m_ready = 1'b1;
    end
  end

  // Monitor: logs every handshaked beat and checks stall stability and input back-pressure.
  always @(negedge i_clk) begin
    if (!reset) begin
      if (prev_stall)
        checkOutput("stall_hold", 64'({m_valid, m_last, m_data}), 64'({1'b1, prev_last, prev_data}));
      if (m_valid) checkOutput("s_ready_busy", 64'(s_ready), 64'(0));
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [31:0] data, input logic last);
    int n;
    n = 0;
    @(posedge i_clk);
    #1;
    s_data  = data;
    s_last  = last;
    s_valid = 1'b1;
    @(negedge i_clk);
    while (!s_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!s_ready) checkOutput("s_ready_timeout", 64'(s_ready), 64'(1));
    @(posedge i_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    exp_words.push_back(data);
  endtask

  task automatic doReset();
    @(negedge i_clk);
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    exp_words.delete();
  endtask

  task automatic expectBeat(input string tag, input logic [31:0] data, input logic last);
    int n;
    logic [32:0] b;
    n = 0;
    while (got_q.size() == 0 && n < 300) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checkOutput({tag, "_present"}, 64'(got_q.size() > 0), 64'(1));
    if (got_q.size() == 0) return;
    b = got_q.pop_front();
    checkOutput(tag, 64'(b), 64'({last, data}));
  endtask

  task automatic expectFrame(input string tag, input logic [31:0] hdr);
    logic [31:0] x;
    x = hdr;
    expectBeat({tag, "_hdr"}, hdr, 1'b0);
    foreach (exp_words[i]) begin
      expectBeat({tag, "_pay"}, exp_words[i], 1'b0);
      x = x ^ exp_words[i];
    end
    expectBeat({tag, "_trl"}, x, 1'b1);
    exp_words.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    doReset();

    @(negedge i_clk);
    checkOutput("rst_s_ready", 64'(s_ready), 64'(1));
    checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
    checkOutput("rst_m_last", 64'(m_last), 64'(0));
    checkOutput("rst_m_data", 64'(m_data), 64'(0));
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'(0));

    $display("[TB] three-word frame");
    applyStimulus(32'h1, 1'b0);
    applyStimulus(32'h2, 1'b0);
    applyStimulus(32'h3, 1'b1);
    expectBeat("t1_hdr", 32'hA5C30003, 1'b0);
    expectBeat("t1_w1", 32'h1, 1'b0);
    expectBeat("t1_w2", 32'h2, 1'b0);
    expectBeat("t1_w3", 32'h3, 1'b0);
    expectBeat("t1_trl", 32'hA5C30003, 1'b1);
    exp_words.delete();
    @(negedge i_clk);
    checkOutput("t1_frame_cnt", 64'(frame_cnt), 64'(1));

    $display("[TB] twenty words without last");
    doReset();
    for (int i = 1; i <= 16; i++) applyStimulus(32'h100 + 32'(i), 1'b0);
    expectFrame("t2_f0", 32'hA5C30010);
    for (int i = 17; i <= 20; i++) applyStimulus(32'h100 + 32'(i), i == 20);
    expectFrame("t2_f1", 32'hA5C30104);

    $display("[TB] output stalls every other cycle");
    toggle_en = 1'b1;
    for (int i = 1; i <= 4; i++) applyStimulus(32'hDEAD0000 + 32'(i), i == 4);
    expectFrame("t3", 32'hA5C30204);
    toggle_en = 1'b0;
    @(negedge i_clk);
    checkOutput("t3_frame_cnt", 64'(frame_cnt), 64'(3));

    $display("[TB] last on the sixteenth word");
    doReset();
    for (int i = 1; i <= 16; i++) applyStimulus(32'h5A000000 + 32'(i), i == 16);
    expectFrame("t4", 32'hA5C30010);
    repeat (6) @(negedge i_clk);
    checkOutput("t4_no_extra", 64'(got_q.size()), 64'(0));
    checkOutput("t4_idle", 64'(m_valid), 64'(0));
    checkOutput("t4_frame_cnt", 64'(frame_cnt), 64'(1));

    $display("[TB] reset during payload");
    for (int i = 1; i <= 10; i++) applyStimulus(32'h1000 + 32'(i), i == 10);
    expectBeat("t5_hdr", 32'hA5C3010A, 1'b0);
    expectBeat("t5_w1", 32'h1001, 1'b0);
    expectBeat("t5_w2", 32'h1002, 1'b0);
    doReset();
    @(negedge i_clk);
    checkOutput("t5_m_valid", 64'(m_valid), 64'(0));
    checkOutput("t5_m_last", 64'(m_last), 64'(0));
    checkOutput("t5_s_ready", 64'(s_ready), 64'(1));
    checkOutput("t5_frame_cnt", 64'(frame_cnt), 64'(0));
    repeat (5) @(negedge i_clk);
    checkOutput("t5_no_trailer", 64'(got_q.size()), 64'(0));
    applyStimulus(32'hA, 1'b0);
    applyStimulus(32'hB, 1'b1);
    expectBeat("t5_new_hdr", 32'hA5C30002, 1'b0);
    expectBeat("t5_new_w1", 32'hA, 1'b0);
    expectBeat("t5_new_w2", 32'hB, 1'b0);
    expectBeat("t5_new_trl", 32'hA5C30003, 1'b1);
    exp_words.delete();

    $display("[TB] sequence wrap over 256 frames");
    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(32'(i * 3 + 5), 1'b1);
      expectFrame("t6", {16'hA5C3, 8'(i), 8'h01});
    end
    @(negedge i_clk);
    checkOutput("t6_frame_cnt", 64'(frame_cnt), 64'(256));
    applyStimulus(32'h77, 1'b1);
    expectBeat("t6_wrap_hdr", 32'hA5C30001, 1'b0);
    expectBeat("t6_wrap_w", 32'h77, 1'b0);
    expectBeat("t6_wrap_trl", 32'hA5C30076, 1'b1);
    exp_words.delete();
    @(negedge i_clk);
    checkOutput("t6_frame_cnt_257", 64'(frame_cnt), 64'(257));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/sim_msg_framer.md
SIM_MSG_FRAMER -- requirements
Module: sim_msg_framer

Interface
REQ-001 Parameter DATA_W, default 32, sets the payload word width in bits; only 32 is supported.
REQ-002 Parameter MAX_WORDS, default 16, sets the maximum payload words per frame; legal range 1..255.
REQ-003 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_data  input  DATA_W  payload word from the DUT.
REQ-006 s_valid  input  1  s_data/s_last valid.
REQ-007 s_last  input  1  marks the final word of a message.
REQ-008 s_ready  output  1  framer accepts a word when s_valid && s_ready.
REQ-009 m_data  output  DATA_W  framed beat toward the socket bridge.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_ready  input  1  bridge consumes a beat when m_valid && m_ready.
REQ-012 m_last  output  1  high on the trailer beat only.
REQ-013 frame_cnt  output  32  count of completed frames; wraps modulo 2^32.

Function
REQ-014 FSM states: FILL, HDR, PAY, TRL.
REQ-015 FILL: s_ready=1 and m_valid=0; each accepted word is written to the buffer and wcnt increments.
REQ-016 FILL->HDR on the accepting edge where s_last=1 or wcnt reaches MAX_WORDS; len is latched from the post-increment wcnt.
REQ-017 If the MAX_WORDS-th word arrives without s_last, the frame closes at len=MAX_WORDS; later words start a new frame.
REQ-018 If the MAX_WORDS-th word arrives with s_last=1, exactly one frame of len=MAX_WORDS results.
REQ-019 HDR: m_data = {16'hA5C3, seq[7:0], len[7:0]}; m_valid=1; HDR->PAY on handshake.
REQ-020 PAY: buffered words are emitted in arrival order, one per handshake; PAY->TRL after beat len.
REQ-021 TRL: m_data = XOR of the header word and all payload words; m_last=1; TRL->FILL on handshake.
REQ-022 TRL handshake increments seq (8-bit, wraps 255->0) and frame_cnt, and clears wcnt.
REQ-023 s_ready=0 in HDR, PAY and TRL; input words are never dropped or overwritten.
REQ-024 While m_valid=1 && m_ready=0, m_data, m_last and m_valid hold stable.
REQ-025 An empty frame is impossible: a frame opens only on an accepted word.
REQ-026 Latency: header is valid the cycle after the closing word is accepted; a frame of n words with m_ready held high occupies n+2 cycles on the output.
REQ-027 The checksum accumulates on the fly with no extra bubble cycle.

Reset
REQ-028 reset=1 at a clock edge forces state=FILL, wcnt=0, seq=0, frame_cnt=0, m_valid=0, m_last=0, s_ready=1 on the next cycle.
REQ-029 Reset mid-frame discards the partial or in-flight frame with no trailer emitted.
REQ-030 m_data reset value is 0; buffer contents need not be reset.

Structure
REQ-031 Package sim_msg_pkg holds the magic constant 16'hA5C3, the FSM state enum and the header field widths.
REQ-032 One sub-module, sim_msg_buf: single-clock MAX_WORDS x DATA_W buffer with write pointer, read pointer and synchronous clear.
REQ-033 Estimated size: 150-250 lines of RTL total.

Verification
REQ-034 Send 3 words 0x1, 0x2, 0x3 (last on 0x3), m_ready=1 -> beats 0xA5C30003, 0x1, 0x2, 0x3, trailer 0xA5C30003^0x1^0x2^0x3 = 0xA5C30003 with m_last=1; frame_cnt=1.
REQ-035 Send 20 words with no last -> frame len 16 (header 0xA5C30010), then after s_last on word 20, frame seq=1 with len 4.
REQ-036 Toggle m_ready 1/0 every cycle on a 4-word frame -> m_data stable while stalled and sequence intact; s_ready=0 until the trailer handshake.
REQ-037 Send 256 single-word frames -> header seq field wraps from 0xFF to 0x00; frame_cnt=256.
REQ-038 Assert reset during PAY of a 10-word frame -> no m_last; next frame header = 0xA5C3_00_nn (seq 0); frame_cnt=0.
REQ-039 Word 16 carries s_last=1 -> exactly one frame with header 0xA5C30010; no empty frame follows.
